// File: rtl/ultrasound_pkg.sv
// ---------------------------------------------------------------------------
// ultrasound_pkg
// Shared types and default timing for the ultrasound echo generator.
//   state_t  : FSM states of the echo generator
//   width_t  : 32-bit unsigned type used for every cycle count and echo width
//   DEF_*    : default timing constants used as parameter defaults by the top
//   in_range / calc_echo_width : echo width rules shared by RTL users
// ---------------------------------------------------------------------------
package ultrasound_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    SETUP,
    ECHO,
    HOLDOFF
  } state_t;

  typedef logic [31:0] width_t;

  localparam int unsigned DEF_CLK_FREQ        = 50_000_000;
  localparam int unsigned DEF_TRIG_MIN_CYCLES = 1;
  localparam int unsigned DEF_SETUP_CYCLES    = 25_000;
  localparam int unsigned DEF_MAX_CM          = 400;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1_900_000;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 500_000;

  // A distance earns a proportional echo only when it is valid and in 1..max_cm.
  function automatic logic in_range(input logic [8:0] cm, input logic valid,
                                    input width_t max_cm);
    width_t cm_w;
    cm_w = width_t'(cm);
    return valid && (cm_w >= 32'd1) && (cm_w <= max_cm);
  endfunction

  // The 9-bit distance is widened before the multiply so no product is truncated.
  function automatic width_t calc_echo_width(input logic [8:0] cm, input logic valid,
                                             input width_t cycles_per_cm,
                                             input width_t max_cm,
                                             input width_t timeout);
    if (in_range(cm, valid, max_cm)) begin
      return width_t'(cm) * cycles_per_cm;
    end
    return timeout;
  endfunction

endpackage

// File: rtl/ultrasound_echo_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every clock cycle.
// It only exists in builds that define ULTRASOUND_NOISE_EN, the only
// configuration in which the echo generator instantiates it.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, loads SEED
//   lfsr_q : current LFSR state
// ---------------------------------------------------------------------------
`ifdef ULTRASOUND_NOISE_EN
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_q
);

  logic feedback;

  // Tap numbering is 1-based from the LSB, so tap 16 is bit 15.
  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/ultrasound_echo_gen.sv
// ---------------------------------------------------------------------------
// ultrasound_echo_gen
// Emulates an HC-SR04 style ultrasonic ranger: a qualified trigger pulse is
// followed by a fixed burst delay and then an echo pulse whose width encodes
// the latched distance (or a timeout width when there is no valid target).
// Optional build macro ULTRASOUND_NOISE_EN adds LFSR-based jitter of -8..+7
// cycles to in-range echo widths.
// Ports:
//   clk              : system clock, rising edge
//   rst_n            : asynchronous active-low reset
//   trigger          : trigger from the measuring controller (same clock domain)
//   distance_cm      : emulated target distance in cm
//   distance_valid   : 1 = target present, 0 = no object
//   echo             : echo pulse to the controller
//   busy             : high in every state except IDLE
//   meas_done        : one-cycle pulse on the first cycle after echo falls
//   ignored_trig_cnt : saturating count of trigger rises seen while measuring
// ---------------------------------------------------------------------------
module ultrasound_echo_gen
  import ultrasound_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = DEF_CLK_FREQ,
  parameter int unsigned TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
  parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int unsigned CYCLES_PER_CM   = CLK_FREQ * 2 / 34000,
  parameter int unsigned MAX_CM          = DEF_MAX_CM,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  input  logic       distance_valid,
  output logic       echo,
  output logic       busy,
  output logic       meas_done,
  output logic [7:0] ignored_trig_cnt
);

  state_t     state_q, state_d;
  width_t     cnt_q, cnt_d;
  logic       meas_done_q, meas_done_d;
  logic       trig_q;
  logic       trig_rise;
  logic [8:0] latched_cm_q;
  logic       latched_valid_q;
  logic [7:0] ignored_q;
  logic       latch_en;
  width_t     base_width;
  width_t     echo_width;

  // A trigger held high across HOLDOFF->IDLE produces no rise, so it is not accepted.
  assign trig_rise = trigger & ~trig_q;
  assign latch_en  = (state_q == IDLE) && trig_rise;

  assign base_width = calc_echo_width(latched_cm_q, latched_valid_q,
                                      width_t'(CYCLES_PER_CM), width_t'(MAX_CM),
                                      width_t'(TIMEOUT_CYCLES));

`ifdef ULTRASOUND_NOISE_EN
  logic [15:0]        lfsr_q;
  logic [3:0]         jitter_q;
  logic signed [33:0] jittered;

  lfsr16 #(.SEED(16'hACE1)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_q (lfsr_q)
  );

  // Jitter is captured together with the distance so it stays fixed per measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jitter_q <= '0;
    end else if (latch_en) begin
      jitter_q <= lfsr_q[3:0];
    end
  end

  // Jitter only perturbs proportional echoes; the result never drops below one cycle.
  always_comb begin
    jittered   = $signed({2'b00, base_width}) + 34'($signed(jitter_q));
    echo_width = base_width;
    if (in_range(latched_cm_q, latched_valid_q, width_t'(MAX_CM))) begin
      if (jittered < 34'sd1) begin
        echo_width = 32'd1;
      end else begin
        echo_width = jittered[31:0];
      end
    end
  end
`else
  assign echo_width = base_width;
`endif

  // State, counter, trigger history and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      meas_done_q <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      meas_done_q <= meas_done_d;
      trig_q      <= trigger;
    end
  end

  // Distance is frozen on acceptance so later input changes cannot disturb a measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latched_cm_q    <= '0;
      latched_valid_q <= 1'b0;
    end else if (latch_en) begin
      latched_cm_q    <= distance_cm;
      latched_valid_q <= distance_valid;
    end
  end

  // Trigger rises during SETUP, ECHO or HOLDOFF are counted but otherwise ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ignored_q <= '0;
    end else if (trig_rise && (ignored_q != 8'hFF) &&
                 ((state_q == SETUP) || (state_q == ECHO) || (state_q == HOLDOFF))) begin
      ignored_q <= ignored_q + 8'd1;
    end
  end

  // Next-state logic. In TRIG the rising-edge cycle seen in IDLE is part of the
  // high time, hence the +1 when the trigger length is qualified.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    meas_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (trigger) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = '0;
          if ((cnt_q + 32'd1) >= width_t'(TRIG_MIN_CYCLES)) begin
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SETUP: begin
        if (cnt_q == width_t'(SETUP_CYCLES - 1)) begin
          state_d = ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ECHO: begin
        if (cnt_q == (echo_width - 32'd1)) begin
          state_d     = HOLDOFF;
          cnt_d       = '0;
          meas_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == width_t'(HOLDOFF_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Echo is decoded straight from the state register so reset drops it at once.
  assign echo             = (state_q == ECHO);
  assign busy             = (state_q != IDLE);
  assign meas_done        = meas_done_q;
  assign ignored_trig_cnt = ignored_q;

endmodule

// File: tb/tb_ultrasound_echo_gen.sv
// ---------------------------------------------------------------------------
// tb_ultrasound_echo_gen
// Self-checking bench for ultrasound_echo_gen with small timing parameters.
// A table of trigger/distance vectors is applied in a loop; expected echo
// widths go into a scoreboard queue and a negedge monitor pops and compares
// them as each echo pulse ends. Hand-written sequences cover ignored
// triggers, a held trigger across HOLDOFF and a reset in the middle of ECHO.
// ---------------------------------------------------------------------------
module tb_ultrasound_echo_gen;

  localparam int TRIG_MIN = 3;
  localparam int SETUP    = 8;
  localparam int CPCM     = 4;
  localparam int MAXCM    = 400;
  localparam int TIMEOUT  = 1000;
  localparam int HOLDOFF  = 16;

  logic       clk;
  logic       rst_n;
  logic       trigger;
  logic [8:0] distance_cm;
  logic       distance_valid;
  logic       echo;
  logic       busy;
  logic       meas_done;
  logic [7:0] ignored_trig_cnt;

  ultrasound_echo_gen #(
    .TRIG_MIN_CYCLES (TRIG_MIN),
    .SETUP_CYCLES    (SETUP),
    .CYCLES_PER_CM   (CPCM),
    .MAX_CM          (MAXCM),
    .TIMEOUT_CYCLES  (TIMEOUT),
    .HOLDOFF_CYCLES  (HOLDOFF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trigger          (trigger),
    .distance_cm      (distance_cm),
    .distance_valid   (distance_valid),
    .echo             (echo),
    .busy             (busy),
    .meas_done        (meas_done),
    .ignored_trig_cnt (ignored_trig_cnt)
  );

  typedef struct {
    int trig_len;
    int cm;
    bit valid;
    bit expect_echo;
    int width;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int cyc      = 0;
  int rise_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Echo monitor: measures burst delay and echo width, pops the scoreboard.
  int  fall_cyc  = 0;
  int  high_cnt  = 0;
  bit  echo_prev = 1'b0;
  bit  trig_prev = 1'b0;
  bit  md_pending = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      echo_prev  = 1'b0;
      trig_prev  = 1'b0;
      high_cnt   = 0;
      md_pending = 1'b0;
    end else begin
      if (md_pending) begin
        checkOutput("meas_done_one_cycle", int'(meas_done), 0);
        md_pending = 1'b0;
      end
      // cyc here is the last rising edge; the first edge that sees trigger low is cyc+1.
      if (trig_prev && !trigger) fall_cyc = cyc;
      trig_prev = trigger;
      if (echo && !echo_prev) begin
        rise_cnt++;
        high_cnt = 0;
        checkOutput("setup_delay", cyc - (fall_cyc + 1), SETUP);
      end
      if (echo) high_cnt++;
      if (!echo && echo_prev) begin
        checkOutput("meas_done_after_echo", int'(meas_done), 1);
        md_pending = 1'b1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_echo_width", high_cnt, 0);
        end else begin
          checkOutput("echo_width", high_cnt, exp_q.pop_front());
        end
      end
      echo_prev = echo;
    end
  end

  task automatic applyStimulus(input int trig_len, input int cm, input bit valid,
                               input bit expect_echo, input int width);
    @(posedge clk);
    #1;
    distance_cm    = 9'(cm);
    distance_valid = valid;
    trigger        = 1'b1;
    if (expect_echo) exp_q.push_back(width);
    repeat (trig_len) @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("return_to_idle", int'(busy), 0);
  endtask

  task automatic waitEchoLevel(input bit level, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((echo !== level) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(level ? "echo_rise_seen" : "echo_fall_seen", int'(echo), int'(level));
  endtask

  vec_t vecs[9];
  int   rises_before;
  bit   md_seen;

  initial begin
    vecs[0] = '{3, 20,  1'b1, 1'b1, 80};
    vecs[1] = '{2, 20,  1'b1, 1'b0, 0};
    vecs[2] = '{3, 20,  1'b0, 1'b1, 1000};
    vecs[3] = '{3, 401, 1'b1, 1'b1, 1000};
    vecs[4] = '{3, 0,   1'b1, 1'b1, 1000};
    vecs[5] = '{3, 511, 1'b1, 1'b1, 1000};
    vecs[6] = '{3, 400, 1'b1, 1'b1, 1600};
    vecs[7] = '{5, 1,   1'b1, 1'b1, 4};
    vecs[8] = '{3, 137, 1'b1, 1'b1, 548};

    rst_n          = 1'b0;
    trigger        = 1'b0;
    distance_cm    = '0;
    distance_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_echo", int'(echo), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_meas_done", int'(meas_done), 0);
    checkOutput("reset_ignored", int'(ignored_trig_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven measurements
    for (int i = 0; i < 9; i++) begin
      rises_before = rise_cnt;
      applyStimulus(vecs[i].trig_len, vecs[i].cm, vecs[i].valid,
                    vecs[i].expect_echo, vecs[i].width);
      waitIdle(3000);
      checkOutput($sformatf("echo_count_vec%0d", i), rise_cnt - rises_before,
                  int'(vecs[i].expect_echo));
    end
    checkOutput("ignored_after_table", int'(ignored_trig_cnt), 0);

    // Extra triggers and a distance change during ECHO must not disturb it
    applyStimulus(3, 20, 1'b1, 1'b1, 80);
    waitEchoLevel(1'b1, 100);
    repeat (10) @(posedge clk);
    #1;
    trigger     = 1'b1;
    distance_cm = 9'd50;
    repeat (2) @(posedge clk);
    #1 trigger = 1'b0;
    repeat (10) @(posedge clk);
    #1 trigger = 1'b1;
    repeat (2) @(posedge clk);
    #1 trigger = 1'b0;
    waitEchoLevel(1'b0, 200);
    checkOutput("ignored_during_echo", int'(ignored_trig_cnt), 2);

    // Trigger raised in HOLDOFF and held past the return to IDLE is not accepted
    @(posedge clk);
    #1 trigger = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("held_trigger_not_accepted", int'(busy), 0);
    checkOutput("ignored_in_holdoff", int'(ignored_trig_cnt), 3);
    @(posedge clk);
    #1 trigger = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in the middle of ECHO
    applyStimulus(3, 20, 1'b1, 1'b0, 0);
    waitEchoLevel(1'b1, 100);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_echo", int'(echo), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("reset_clears_ignored", int'(ignored_trig_cnt), 0);
    md_seen = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      md_seen = md_seen | meas_done;
    end
    checkOutput("no_meas_done_after_reset", int'(md_seen), 0);

    // Next trigger after reset is served normally
    rises_before = rise_cnt;
    applyStimulus(3, 20, 1'b1, 1'b1, 80);
    waitIdle(3000);
    checkOutput("echo_after_reset", rise_cnt - rises_before, 1);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
